// File: rtl/de_frame.sv
// de_frame: UART RX de-framer. Splits a parallel 11-bit frame (start, data, parity, stop)
// into registered fields and flags whether the frame is well formed. One cycle of latency;
// no enable, every edge samples the input.
module de_frame #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH+2:0] data_parll,
  output logic [DATA_WIDTH-1:0] raw_data,
  output logic                  start_bit,
  output logic                  parity_bit,
  output logic                  stop_bit,
  output logic                  done_flag
);

  localparam int unsigned ParIdx  = DATA_WIDTH + 1;
  localparam int unsigned StopIdx = DATA_WIDTH + 2;

  logic [DATA_WIDTH-1:0] raw_data_d, raw_data_q;
  logic                  start_bit_d, start_bit_q;
  logic                  parity_bit_d, parity_bit_q;
  logic                  stop_bit_d, stop_bit_q;
  logic                  done_flag_d, done_flag_q;

  logic start_ok;
  logic stop_ok;
  logic par_ok;

  // Field slicing and frame validity from the current input sample.
  always_comb begin
    raw_data_d   = data_parll[DATA_WIDTH:1];
    start_bit_d  = data_parll[0];
    parity_bit_d = data_parll[ParIdx];
    stop_bit_d   = data_parll[StopIdx];

    start_ok = ~start_bit_d;
    stop_ok  = stop_bit_d;
    // XOR over payload plus parity bit is 0 for even parity, 1 for odd.
    par_ok   = ((^raw_data_d) ^ parity_bit_d) == PARITY_ODD;

    done_flag_d = start_ok & stop_ok & par_ok;
  end

  // Output registers; reset loads the idle-line field values and clears the valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_data_q   <= '0;
      start_bit_q  <= 1'b1;
      parity_bit_q <= 1'b0;
      stop_bit_q   <= 1'b1;
      done_flag_q  <= 1'b0;
    end else begin
      raw_data_q   <= raw_data_d;
      start_bit_q  <= start_bit_d;
      parity_bit_q <= parity_bit_d;
      stop_bit_q   <= stop_bit_d;
      done_flag_q  <= done_flag_d;
    end
  end

  assign raw_data   = raw_data_q;
  assign start_bit  = start_bit_q;
  assign parity_bit = parity_bit_q;
  assign stop_bit   = stop_bit_q;
  assign done_flag  = done_flag_q;

endmodule

// File: tb/tb_de_frame.sv
// tb_de_frame: scoreboard bench for de_frame. Two instances share one input: even parity
// (default) and odd parity. Expected results are queued at drive time and checked one edge later.
module tb_de_frame;

  typedef struct packed {
    logic [7:0] raw;
    logic       start;
    logic       par;
    logic       stop;
    logic       done_e;
    logic       done_o;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [10:0] data_parll;

  logic [7:0] raw_e, raw_o;
  logic       start_e, start_o, par_e, par_o, stop_e, stop_o, done_e, done_o;

  exp_t sb[$];
  int   n_checks;
  int   n_fail;

  de_frame dut_even (
    .clk        (clk),
    .rst        (rst),
    .data_parll (data_parll),
    .raw_data   (raw_e),
    .start_bit  (start_e),
    .parity_bit (par_e),
    .stop_bit   (stop_e),
    .done_flag  (done_e)
  );

  de_frame #(
    .DATA_WIDTH (8),
    .PARITY_ODD (1'b1)
  ) dut_odd (
    .clk        (clk),
    .rst        (rst),
    .data_parll (data_parll),
    .raw_data   (raw_o),
    .start_bit  (start_o),
    .parity_bit (par_o),
    .stop_bit   (stop_o),
    .done_flag  (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model for random frames, written from the frame format.
  function automatic exp_t model(input logic [10:0] f);
    exp_t e;
    int   ones;
    ones = 0;
    for (int i = 1; i <= 9; i++) ones += int'(f[i]);
    e.raw    = f[8:1];
    e.start  = f[0];
    e.par    = f[9];
    e.stop   = f[10];
    e.done_e = (f[0] == 1'b0) && (f[10] == 1'b1) && (ones % 2 == 0);
    e.done_o = (f[0] == 1'b0) && (f[10] == 1'b1) && (ones % 2 == 1);
    return e;
  endfunction

  localparam exp_t ExpReset = '{raw: 8'h00, start: 1'b1, par: 1'b0, stop: 1'b1,
                                done_e: 1'b0, done_o: 1'b0};

  task automatic apply(input logic [10:0] f, input logic r, input exp_t e);
    @(negedge clk);
    data_parll = f;
    rst        = r;
    sb.push_back(e);
  endtask

  // Monitor: compare each queued expectation just after the edge that produced it.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("raw_data",   32'(raw_e),   32'(e.raw));
      check_eq("start_bit",  32'(start_e), 32'(e.start));
      check_eq("parity_bit", 32'(par_e),   32'(e.par));
      check_eq("stop_bit",   32'(stop_e),  32'(e.stop));
      check_eq("done_even",  32'(done_e),  32'(e.done_e));
      check_eq("done_odd",   32'(done_o),  32'(e.done_o));
      check_eq("raw_odd",    32'(raw_o),   32'(e.raw));
      check_eq("fields_odd", 32'({start_o, par_o, stop_o}), 32'({e.start, e.par, e.stop}));
    end
  end

  initial begin
    logic [10:0] f;
    int          waited;
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    data_parll = 11'h54A;

    // Reset held for two cycles with a valid frame on the input.
    apply(11'h54A, 1'b1, ExpReset);
    apply(11'h54A, 1'b1, ExpReset);

    // Directed frames with hand-derived expectations.
    apply(11'h54A, 1'b0, '{8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    apply(11'h54A, 1'b0, '{8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}); // level, not pulse
    apply(11'h74A, 1'b0, '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1});
    apply(11'h54B, 1'b0, '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    apply(11'h14A, 1'b0, '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    apply(11'h7FF, 1'b0, '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    apply(11'h400, 1'b0, '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    apply(11'h600, 1'b0, '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1});

    // Random frames, a mid-stream reset, then more random frames.
    for (int i = 0; i < 20; i++) begin
      f = 11'($urandom_range(0, 2047));
      apply(f, 1'b0, model(f));
    end
    apply(11'h54A, 1'b1, ExpReset);
    for (int i = 0; i < 12; i++) begin
      f = 11'($urandom_range(0, 2047));
      apply(f, 1'b0, model(f));
    end

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    check_eq("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
